// File: rtl/fret_scanner_pkg.sv
// Shared types and widths for the fret scanner: luma width, lane state
// encoding, debounce/strum counter widths and the RGB-to-luma helper.
package fret_scanner_pkg;

  localparam int LUMA_W   = 10;
  localparam int SMOOTH_W = 4;
  localparam int STRUM_W  = 4;

  typedef enum logic {
    LANE_RELEASED = 1'b0,
    LANE_PRESSED  = 1'b1
  } laneStateT;

  // R+G+B tops out at 765, so 10 bits never overflow.
  function automatic logic [LUMA_W-1:0] rgbLuma(input logic [23:0] rgb);
    return {2'b00, rgb[23:16]} + {2'b00, rgb[15:8]} + {2'b00, rgb[7:0]};
  endfunction

endpackage

// File: rtl/fret_lane.sv
// One detection lane: point sampling, press/release hysteresis and frame-rate
// debounce. FRET_SCANNER_CAPTURE_EN adds a last-sampled-luma register.
module fret_lane
  import fret_scanner_pkg::*;
#(
  parameter int X_W = 11,
  parameter int Y_W = 10
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                enable,
  input  logic                boundary,
  input  logic                sampleEn,
  input  logic [X_W-1:0]      colCnt,
  input  logic [Y_W-1:0]      lineCnt,
  input  logic [X_W-1:0]      laneX,
  input  logic [Y_W-1:0]      laneY,
  input  logic [23:0]         rgbPixel,
  input  logic [LUMA_W-1:0]   trigOn,
  input  logic [LUMA_W-1:0]   trigOff,
  input  logic [SMOOTH_W-1:0] smoothingVal,
  output logic                laneState,
  output logic                pressRise
`ifdef FRET_SCANNER_CAPTURE_EN
  ,
  output logic [LUMA_W-1:0]   sampleLuma
`endif
);

  laneStateT           state, stateNext;
  logic [SMOOTH_W-1:0] cnt, cntNext;
  logic                cand, candNext;
  logic                sampled, sampledNext;
  logic                hit;
  logic [LUMA_W-1:0]   luma;

  assign hit       = enable && sampleEn && (colCnt == laneX) && (lineCnt == laneY);
  assign luma      = rgbLuma(rgbPixel);
  assign laneState = (state == LANE_PRESSED);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= LANE_RELEASED;
      cnt     <= '0;
      cand    <= 1'b0;
      sampled <= 1'b0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      cand    <= candNext;
      sampled <= sampledNext;
    end
  end

  // Candidate is re-evaluated on every hit so only the last sample of a frame counts.
  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    candNext    = cand;
    sampledNext = sampled;
    pressRise   = 1'b0;
    if (!enable) begin
      stateNext   = LANE_RELEASED;
      cntNext     = '0;
      candNext    = 1'b0;
      sampledNext = 1'b0;
    end else if (boundary) begin
      if (sampled && cand) begin
        if (cnt >= smoothingVal) begin
          stateNext = (state == LANE_RELEASED) ? LANE_PRESSED : LANE_RELEASED;
          cntNext   = '0;
          pressRise = (state == LANE_RELEASED);
        end else if (cnt != '1) begin
          cntNext = cnt + 1'b1;
        end
      end else begin
        cntNext = '0;
      end
      candNext    = 1'b0;
      sampledNext = 1'b0;
    end else if (hit) begin
      sampledNext = 1'b1;
      candNext    = (state == LANE_RELEASED) ? (luma >= trigOn) : (luma <= trigOff);
    end
  end

`ifdef FRET_SCANNER_CAPTURE_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)   sampleLuma <= '0;
    else if (hit) sampleLuma <= luma;
  end
`endif

endmodule

// File: rtl/fret_scanner.sv
// Video-timing driven fret detector: column/line counters, per-lane detection
// and frame-granular strum pulse. Optional FRET_SCANNER_CAPTURE_EN adds sample_luma.
module fret_scanner
  import fret_scanner_pkg::*;
#(
  parameter int NUM_LANES = 5,
  parameter int X_W       = 11,
  parameter int Y_W       = 10
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        enable,
  input  logic                        vsync,
  input  logic                        hsync,
  input  logic                        vde,
  input  logic [23:0]                 rgb_pixel,
  input  logic [NUM_LANES*X_W-1:0]    lane_x,
  input  logic [NUM_LANES*Y_W-1:0]    lane_y,
  input  logic [NUM_LANES*LUMA_W-1:0] trig_on,
  input  logic [NUM_LANES*LUMA_W-1:0] trig_off,
  input  logic [SMOOTH_W-1:0]         smoothing_val,
  input  logic [STRUM_W-1:0]          strum_time,
  output logic [NUM_LANES-1:0]        press,
  output logic                        strum,
  output logic                        frame_tick
`ifdef FRET_SCANNER_CAPTURE_EN
  ,
  output logic [NUM_LANES*LUMA_W-1:0] sample_luma
`endif
);

  logic                 vsyncQ, hsyncQ;
  logic                 vsyncRise, hsyncRise;
  logic [X_W-1:0]       colCnt;
  logic [Y_W-1:0]       lineCnt;
  logic                 lineHasVde;
  logic                 frameValid;
  logic [STRUM_W-1:0]   strumCnt;
  logic [NUM_LANES-1:0] pressRise;

  assign vsyncRise = vsync && !vsyncQ;
  assign hsyncRise = hsync && !hsyncQ;
  assign strum     = (strumCnt != '0);

  // frameValid blocks sampling after reset until the line count is trustworthy.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vsyncQ     <= 1'b0;
      hsyncQ     <= 1'b0;
      frame_tick <= 1'b0;
      colCnt     <= '0;
      lineCnt    <= '0;
      lineHasVde <= 1'b0;
      frameValid <= 1'b0;
    end else begin
      vsyncQ     <= vsync;
      hsyncQ     <= hsync;
      frame_tick <= vsyncRise;
      if (hsyncRise)                colCnt <= '0;
      else if (vde && colCnt != '1) colCnt <= colCnt + 1'b1;
      if (vsyncRise) begin
        lineCnt    <= '0;
        lineHasVde <= vde;
        frameValid <= 1'b1;
      end else if (hsyncRise) begin
        if (lineHasVde && lineCnt != '1) lineCnt <= lineCnt + 1'b1;
        lineHasVde <= vde;
      end else if (vde) begin
        lineHasVde <= 1'b1;
      end
    end
  end

  // A new press reloads the counter, so overlapping presses extend the pulse without a gap.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      strumCnt <= '0;
    end else if (!enable) begin
      strumCnt <= '0;
    end else if (vsyncRise) begin
      if (|pressRise)           strumCnt <= (strum_time == '0) ? STRUM_W'(1) : strum_time;
      else if (strumCnt != '0) strumCnt <= strumCnt - 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
    fret_lane #(
      .X_W(X_W),
      .Y_W(Y_W)
    ) uLane (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .enable      (enable),
      .boundary    (vsyncRise),
      .sampleEn    (vde && frameValid),
      .colCnt      (colCnt),
      .lineCnt     (lineCnt),
      .laneX       (lane_x[i*X_W +: X_W]),
      .laneY       (lane_y[i*Y_W +: Y_W]),
      .rgbPixel    (rgb_pixel),
      .trigOn      (trig_on[i*LUMA_W +: LUMA_W]),
      .trigOff     (trig_off[i*LUMA_W +: LUMA_W]),
      .smoothingVal(smoothing_val),
      .laneState   (press[i]),
      .pressRise   (pressRise[i])
`ifdef FRET_SCANNER_CAPTURE_EN
      ,
      .sampleLuma  (sample_luma[i*LUMA_W +: LUMA_W])
`endif
    );
  end

endmodule

// File: tb/tb_fret_scanner.sv
// Directed bench for fret_scanner: small synthetic frames with per-lane luma
// at known points, checked with immediate assertions after each frame boundary.
module tb_fret_scanner;

  localparam int NL = 8;
  localparam int XW = 11;
  localparam int YW = 10;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             enable, vsync, hsync, vde;
  logic [23:0]      rgb_pixel;
  logic [NL*XW-1:0] lane_x;
  logic [NL*YW-1:0] lane_y;
  logic [NL*10-1:0] trig_on, trig_off;
  logic [3:0]       smoothing_val, strum_time;
  logic [NL-1:0]    press;
  logic             strum, frame_tick;
`ifdef FRET_SCANNER_CAPTURE_EN
  logic [NL*10-1:0] sample_luma;
`endif

  fret_scanner #(.NUM_LANES(NL), .X_W(XW), .Y_W(YW)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .enable       (enable),
    .vsync        (vsync),
    .hsync        (hsync),
    .vde          (vde),
    .rgb_pixel    (rgb_pixel),
    .lane_x       (lane_x),
    .lane_y       (lane_y),
    .trig_on      (trig_on),
    .trig_off     (trig_off),
    .smoothing_val(smoothing_val),
    .strum_time   (strum_time),
    .press        (press),
    .strum        (strum),
    .frame_tick   (frame_tick)
`ifdef FRET_SCANNER_CAPTURE_EN
    ,
    .sample_luma  (sample_luma)
`endif
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int lane_xv[NL];
  int lane_yv[NL];
  int luma_v[NL];

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [23:0] mk_rgb(input int v);
    int r, g, b;
    r = (v > 255) ? 255 : v;
    v = v - r;
    g = (v > 255) ? 255 : v;
    b = v - g;
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  function automatic logic [23:0] pix(input int ln, input int p);
    logic [23:0] val;
    val = '0;
    for (int i = 0; i < NL; i++)
      if (lane_xv[i] == p && lane_yv[i] == ln) val = mk_rgb(luma_v[i]);
    return val;
  endfunction

  task automatic apply_cfg();
    for (int i = 0; i < NL; i++) begin
      lane_x[i*XW +: XW]  = XW'(lane_xv[i]);
      lane_y[i*YW +: YW]  = YW'(lane_yv[i]);
      trig_on[i*10 +: 10]  = 10'd500;
      trig_off[i*10 +: 10] = 10'd400;
    end
  endtask

  task automatic active_frame(input int nlines, input int width);
    for (int ln = 0; ln < nlines; ln++) begin
      hsync = 1'b1; tick();
      hsync = 1'b0; tick();
      for (int p = 0; p < width; p++) begin
        vde = 1'b1;
        rgb_pixel = pix(ln, p);
        tick();
      end
      vde = 1'b0;
      rgb_pixel = '0;
      tick();
    end
  endtask

  task automatic boundary(input string tag);
    vsync = 1'b1; tick();
    chk({tag, "_tick"}, frame_tick, 1);
    tick();
    chk({tag, "_tick_clr"}, frame_tick, 0);
    vsync = 1'b0; tick();
  endtask

  task automatic run_frame(input string tag);
    active_frame(2, 10);
    boundary(tag);
  endtask

  initial begin
    RST_N = 1'b0; enable = 1'b1;
    vsync = 1'b0; hsync = 1'b0; vde = 1'b0; rgb_pixel = '0;
    smoothing_val = 4'd2; strum_time = 4'd3;
    for (int i = 0; i < 5; i++) begin
      lane_xv[i] = i + 1;
      lane_yv[i] = i % 2;
    end
    lane_xv[5] = 0;    lane_yv[5] = 0;
    lane_xv[6] = 9;    lane_yv[6] = 1;
    lane_xv[7] = 2047; lane_yv[7] = 0;
    for (int i = 0; i < NL; i++) luma_v[i] = 0;
    apply_cfg();

    #3;
    chk("rst_press", press, 0);
    chk("rst_strum", strum, 0);
    chk("rst_tick", frame_tick, 0);
    repeat (2) tick();
    RST_N = 1'b1;
    tick();
    boundary("b0");

    // debounce: three qualifying frames with smoothing 2; lane1 starts one frame later
    luma_v[0] = 600;
    run_frame("f1"); chk("f1_press", press, 8'h00);
    luma_v[1] = 600;
    run_frame("f2"); chk("f2_press", press, 8'h00);
    run_frame("f3"); chk("f3_press", press, 8'h01); chk("f3_strum", strum, 1);
    run_frame("f4"); chk("f4_press", press, 8'h03); chk("f4_strum", strum, 1);
    run_frame("f5"); chk("f5_strum", strum, 1);
    run_frame("f6"); chk("f6_strum", strum, 1);
    run_frame("f7"); chk("f7_strum", strum, 0); chk("f7_press", press, 8'h03);

    // hysteresis then release
    luma_v[0] = 450;
    run_frame("f8");  chk("f8_press", press, 8'h03);
    run_frame("f9");  chk("f9_press", press, 8'h03);
    luma_v[0] = 390;
    run_frame("f10"); chk("f10_press", press, 8'h03); chk("f10_strum", strum, 0);
    run_frame("f11"); chk("f11_press", press, 8'h03);
    run_frame("f12"); chk("f12_press", press, 8'h02); chk("f12_strum", strum, 0);

    // strum_time 0 and smoothing 0
    smoothing_val = 4'd0; strum_time = 4'd0;
    luma_v[0] = 0; luma_v[2] = 600;
    run_frame("f13"); chk("f13_press", press, 8'h06); chk("f13_strum", strum, 1);
    run_frame("f14"); chk("f14_press", press, 8'h06); chk("f14_strum", strum, 0);

    // enable low clears lanes and strum
    luma_v[3] = 600;
    run_frame("f15"); chk("f15_press", press, 8'h0e); chk("f15_strum", strum, 1);
    enable = 1'b0; tick();
    chk("en_press", press, 8'h00); chk("en_strum", strum, 0);
    enable = 1'b1; tick();
    luma_v[1] = 0;
    run_frame("f16"); chk("f16_press", press, 8'h0c); chk("f16_strum", strum, 1);

    // asynchronous reset between vsync edges
    active_frame(2, 10);
    RST_N = 1'b0;
    #2;
    chk("mid_rst_press", press, 8'h00);
    chk("mid_rst_strum", strum, 0);
    tick();
    RST_N = 1'b1;
    active_frame(2, 10);
    boundary("r1");
    chk("r1_press", press, 8'h00);
    run_frame("f18"); chk("f18_press", press, 8'h0c); chk("f18_strum", strum, 1);

    // coincident vsync/hsync rise and saturated column
    for (int i = 0; i < NL; i++) luma_v[i] = 0;
    active_frame(2, 10);
    vsync = 1'b1; hsync = 1'b1; tick();
    chk("co_tick", frame_tick, 1);
    tick();
    vsync = 1'b0; hsync = 1'b0; tick();
    for (int p = 0; p < 2060; p++) begin
      vde = 1'b1;
      rgb_pixel = (p == 0 || p >= 2048) ? mk_rgb(600) : 24'h0;
      tick();
    end
    vde = 1'b0; rgb_pixel = '0; tick();
    boundary("fl");
    chk("sat_press", press, 8'ha0);
    chk("sat_strum", strum, 1);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
